// File: rtl/cdm_msgld_pkg.sv
// cdm_msgld_pkg: shared FSM state, request layout, sizing constants and the expected data pattern
// for the MSGLD tracker.
package cdm_msgld_pkg;

    localparam int MAX_TAGS   = 64;
    localparam int DATA_W     = 256;
    localparam int LANES      = DATA_W / 32;
    localparam int DATA_BYTES = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [63:0] addr;
        logic [11:0] len;
        logic [7:0]  tag;
        logic [7:0]  func;
        logic [3:0]  attr;
    } msgld_req_t;

    // Each 32-bit lane carries address bits [31:8] over its own lane index.
    function automatic logic [DATA_W-1:0] exp_pattern(input logic [23:0] addr_hi);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < LANES; i++) d[i*32 +: 32] = {addr_hi, 8'(i)};
        return d;
    endfunction

endpackage

// File: rtl/cdx5n_dsc_crd_in_msgld_req_if.sv
// cdx5n_dsc_crd_in_msgld_req_if: descriptor-credit MSGLD request channel (vld/rdy handshake).
interface cdx5n_dsc_crd_in_msgld_req_if;
    import cdm_msgld_pkg::*;

    logic       vld;
    logic       rdy;
    msgld_req_t intf;

    modport master (output vld, output intf, input rdy);
    modport slave  (input vld, input intf, output rdy);

endinterface

// File: rtl/cdx5n_mm_byp_out_rsp_if.sv
// cdx5n_mm_byp_out_rsp_if: bypass-out MSGLD response channel carrying tag, last flag and data.
interface cdx5n_mm_byp_out_rsp_if;
    import cdm_msgld_pkg::*;

    logic              vld;
    logic              rdy;
    logic [7:0]        tag;
    logic              last;
    logic [DATA_W-1:0] data;

    modport master (output vld, output tag, output last, output data, input rdy);
    modport slave  (input vld, input tag, input last, input data, output rdy);

endinterface

// File: rtl/cdm_tag_pool.sv
// cdm_tag_pool: free-tag bitmap with lowest-free priority encoder and outstanding popcount.
// A same-cycle free and allocate applies the free first, so the allocation wins.
module cdm_tag_pool #(
    parameter int NUM_TAGS = 16,
    parameter int TAG_W    = $clog2(NUM_TAGS)
) (
    input  logic                user_clk,
    input  logic                user_reset,
    input  logic                alloc,
    input  logic [TAG_W-1:0]    alloc_tag,
    input  logic                free,
    input  logic [TAG_W-1:0]    free_tag,
    output logic [NUM_TAGS-1:0] free_map,
    output logic                any_free,
    output logic [TAG_W-1:0]    low_free,
    output logic [TAG_W:0]      count
);
    localparam int CW = TAG_W + 1;

    logic [NUM_TAGS-1:0] alloc_vec;
    logic [NUM_TAGS-1:0] free_vec;

    always_comb begin
        alloc_vec = '0;
        free_vec  = '0;
        alloc_vec[alloc_tag] = alloc;
        free_vec[free_tag]   = free;
    end

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) free_map <= '1;
        else free_map <= (free_map | free_vec) & ~alloc_vec;
    end

    assign any_free = |free_map;

    always_comb begin
        low_free = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) if (free_map[i]) low_free = TAG_W'(i);
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_TAGS; i++) count = count + CW'(!free_map[i]);
    end

endmodule

// File: rtl/cdm_msgld_tracker.sv
// cdm_msgld_tracker: issues a programmed run of MSGLD requests from a bounded tag pool and
// retires their responses, counting tag errors (and data errors with CDM_MSGLD_DATA_CHECK_EN).
module cdm_msgld_tracker
    import cdm_msgld_pkg::*;
#(
    parameter int TCQ      = 1,
    parameter int NUM_TAGS = 16,
    parameter int TAG_W    = $clog2(NUM_TAGS)
) (
    input  logic                         user_clk,
    input  logic                         user_reset,
    input  logic                         start,
    input  logic [15:0]                  num_req,
    input  logic [63:0]                  base_addr,
    input  logic [11:0]                  req_len,
    cdx5n_dsc_crd_in_msgld_req_if.master msgld_req,
    cdx5n_mm_byp_out_rsp_if.slave        msgld_rsp,
    output logic                         busy,
    output logic                         done,
    output logic [TAG_W:0]               outstanding,
    output logic [15:0]                  req_cnt,
    output logic [15:0]                  err_cnt
);
    if (NUM_TAGS < 2 || NUM_TAGS > MAX_TAGS || (NUM_TAGS & (NUM_TAGS - 1)) != 0 || TCQ < 0) begin : g_bad_param
        $error("cdm_msgld_tracker: unsupported parameter set");
    end

    state_t              state, state_nxt;
    logic [15:0]         num_req_q;
    logic [63:0]         addr_q;
    logic [11:0]         len_q;
    logic                held_q;
    logic [TAG_W-1:0]    held_tag_q;
    logic [NUM_TAGS-1:0] free_map;
    logic                any_free;
    logic [TAG_W-1:0]    low_free;
    logic [TAG_W-1:0]    req_tag;
    logic [TAG_W-1:0]    rsp_idx;
    logic                req_vld, req_acc, start_ok;
    logic                rsp_rdy, beat, tag_ok, tag_err, data_err, rsp_free, err_inc;
    msgld_req_t          req_intf;

    cdm_tag_pool #(.NUM_TAGS(NUM_TAGS), .TAG_W(TAG_W)) u_tag_pool (
        .user_clk  (user_clk),
        .user_reset(user_reset),
        .alloc     (req_acc),
        .alloc_tag (req_tag),
        .free      (rsp_free),
        .free_tag  (rsp_idx),
        .free_map  (free_map),
        .any_free  (any_free),
        .low_free  (low_free),
        .count     (outstanding)
    );

    // A stalled request keeps its tag even if a lower tag frees meanwhile.
    assign req_tag  = held_q ? held_tag_q : low_free;
    assign req_vld  = (state == ISSUE) && any_free;
    assign req_acc  = req_vld && msgld_req.rdy;
    assign start_ok = start && (state == IDLE);

    always_comb begin
        req_intf = '0;
        if (req_vld) begin
            req_intf.addr = addr_q;
            req_intf.len  = len_q;
            req_intf.tag  = 8'(req_tag);
        end
    end

    assign msgld_req.vld  = req_vld;
    assign msgld_req.intf = req_intf;

    assign rsp_rdy        = state != IDLE;
    assign msgld_rsp.rdy  = rsp_rdy;
    assign rsp_idx        = msgld_rsp.tag[TAG_W-1:0];
    assign beat           = msgld_rsp.vld && rsp_rdy;
    assign tag_ok         = (msgld_rsp.tag < 8'(NUM_TAGS)) && !free_map[rsp_idx];
    assign tag_err        = beat && !tag_ok;
    assign rsp_free       = beat && tag_ok && msgld_rsp.last;
    assign err_inc        = tag_err || data_err;

`ifdef CDM_MSGLD_DATA_CHECK_EN
    logic [63:0] exp_addr [NUM_TAGS];

    always_ff @(posedge user_clk) begin
        if (req_acc) exp_addr[req_tag] <= addr_q;
        if (beat && tag_ok) exp_addr[rsp_idx] <= exp_addr[rsp_idx] + 64'(DATA_BYTES);
    end

    assign data_err = beat && tag_ok && (msgld_rsp.data != exp_pattern(exp_addr[rsp_idx][31:8]));
`else
    logic unused_data;
    assign unused_data = ^msgld_rsp.data;
    assign data_err    = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = start ? ((num_req == 16'd0) ? DONE : ISSUE) : IDLE;
            ISSUE:   state_nxt = (req_acc && (req_cnt + 16'd1 == num_req_q)) ? DRAIN : ISSUE;
            DRAIN:   state_nxt = (outstanding == '0) ? DONE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            state      <= IDLE;
            num_req_q  <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            held_q     <= 1'b0;
            held_tag_q <= '0;
            req_cnt    <= '0;
            err_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            held_q     <= req_vld && !msgld_req.rdy;
            held_tag_q <= req_tag;
            if (start_ok) begin
                num_req_q <= num_req;
                addr_q    <= base_addr;
                len_q     <= req_len;
                req_cnt   <= '0;
                err_cnt   <= '0;
            end
            if (req_acc) begin
                addr_q  <= addr_q + 64'(len_q);
                req_cnt <= req_cnt + 16'd1;
            end
            if (err_inc && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end

    assign busy = state != IDLE;
    assign done = state == DONE;

endmodule

// File: tb/tb_cdm_msgld_tracker.sv
// tb_cdm_msgld_tracker: directed scoreboard bench for cdm_msgld_tracker (NUM_TAGS=16).
module tb_cdm_msgld_tracker;
    import cdm_msgld_pkg::*;

    localparam int NT = 16;

    logic        user_clk = 1'b0;
    logic        user_reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_req = '0;
    logic [63:0] base_addr = '0;
    logic [11:0] req_len = '0;
    logic        busy, done;
    logic [4:0]  outstanding;
    logic [15:0] req_cnt, err_cnt;

    cdx5n_dsc_crd_in_msgld_req_if msgld_req();
    cdx5n_mm_byp_out_rsp_if       msgld_rsp();

    always #5 user_clk = ~user_clk;

    cdm_msgld_tracker #(.TCQ(1), .NUM_TAGS(NT)) dut (
        .user_clk   (user_clk),
        .user_reset (user_reset),
        .start      (start),
        .num_req    (num_req),
        .base_addr  (base_addr),
        .req_len    (req_len),
        .msgld_req  (msgld_req),
        .msgld_rsp  (msgld_rsp),
        .busy       (busy),
        .done       (done),
        .outstanding(outstanding),
        .req_cnt    (req_cnt),
        .err_cnt    (err_cnt)
    );

    int          checks = 0;
    int          failures = 0;
    int          done_seen = 0;
    logic [63:0] sb_q[$];
    logic [11:0] cur_len = '0;
    logic [NT-1:0] m_alloc = '0;
    logic [63:0] m_addr [NT];
    logic        stalled = 1'b0;
    logic [7:0]  held_tag = '0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [7:0] low_free(input logic [NT-1:0] a);
        for (int i = 0; i < NT; i++) if (!a[i]) return 8'(i);
        return 8'hFF;
    endfunction

    function automatic logic [7:0] low_alloc(input logic [NT-1:0] a);
        for (int i = 0; i < NT; i++) if (a[i]) return 8'(i);
        return 8'hFF;
    endfunction

    function automatic logic [DATA_W-1:0] pat(input logic [63:0] a);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = {a[31:8], 8'(i)};
        return d;
    endfunction

    // One clock: drive inputs, check any presented request against the scoreboard, update model, tick.
    task automatic cycle(input logic rdy, input logic rv, input logic [7:0] rt, input logic [DATA_W-1:0] rd);
        logic [7:0] et;
        logic       acc, fr;
        msgld_req.rdy  = rdy;
        msgld_rsp.vld  = rv;
        msgld_rsp.tag  = rt;
        msgld_rsp.last = 1'b1;
        msgld_rsp.data = rd;
        acc = msgld_req.vld && rdy;
        fr  = rv && msgld_rsp.rdy && (rt < 8'(NT)) && m_alloc[rt[3:0]];
        et  = stalled ? held_tag : low_free(m_alloc);
        if (msgld_req.vld) begin
            chk("req_tag", 64'(msgld_req.intf.tag), 64'(et));
            chk("req_pending", 64'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                chk("req_addr", msgld_req.intf.addr, sb_q[0]);
                chk("req_len", 64'(msgld_req.intf.len), 64'(cur_len));
            end
        end
        if (fr) m_alloc[rt[3:0]] = 1'b0;
        if (acc && sb_q.size() > 0 && et < 8'(NT)) begin
            m_alloc[et[3:0]] = 1'b1;
            m_addr[et[3:0]]  = sb_q.pop_front();
        end
        stalled  = msgld_req.vld && !rdy;
        held_tag = et;
        if (done) done_seen++;
        @(posedge user_clk);
        #1;
    endtask

    task automatic start_run(input int n, input logic [63:0] b, input logic [11:0] l);
        num_req   = 16'(n);
        base_addr = b;
        req_len   = l;
        cur_len   = l;
        for (int i = 0; i < n; i++) sb_q.push_back(b + 64'(i) * 64'(l));
        start = 1'b1;
        cycle(1'b0, 1'b0, 8'd0, '0);
        start = 1'b0;
    endtask

    // Keep answering the lowest outstanding tag until done is seen or the budget runs out.
    task automatic run_to_done(input bit rnd, input int budget);
        int         n;
        int         d0;
        logic [7:0] t;
        n  = 0;
        d0 = done_seen;
        while (done_seen == d0 && n < budget) begin
            t = low_alloc(m_alloc);
            cycle(rnd ? 1'($urandom_range(0, 1)) : 1'b1, t != 8'hFF, t, (t != 8'hFF) ? pat(m_addr[t[3:0]]) : '0);
            n++;
        end
        chk("run_done_pulses", 64'(done_seen - d0), 1);
        chk("run_busy_after", 64'(busy), 0);
    endtask

    initial begin
        logic [DATA_W-1:0] bad;
        int                exp_data_err;
        msgld_req.rdy  = 1'b0;
        msgld_rsp.vld  = 1'b0;
        msgld_rsp.tag  = '0;
        msgld_rsp.last = 1'b0;
        msgld_rsp.data = '0;
        repeat (2) @(posedge user_clk);
        #1;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_outstanding", 64'(outstanding), 0);
        chk("rst_req_cnt", 64'(req_cnt), 0);
        chk("rst_err_cnt", 64'(err_cnt), 0);
        chk("rst_req_vld", 64'(msgld_req.vld), 0);
        chk("rst_rsp_rdy", 64'(msgld_rsp.rdy), 0);
        chk("rst_intf_zero", 64'(msgld_req.intf === '0), 1);
        user_reset = 1'b0;
        cycle(1'b0, 1'b0, 8'd0, '0);

        // zero-length run goes straight to DONE
        start_run(0, 64'h0, 12'd1);
        chk("zero_done", 64'(done), 1);
        chk("zero_busy", 64'(busy), 1);
        cycle(1'b1, 1'b0, 8'd0, '0);
        chk("zero_idle_done", 64'(done), 0);
        chk("zero_idle_busy", 64'(busy), 0);

        // basic run: issue 4, then answer in order
        start_run(4, 64'h1000, 12'd64);
        chk("basic_busy", 64'(busy), 1);
        chk("basic_first_vld", 64'(msgld_req.vld), 1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'd0, '0);
        chk("basic_req_cnt", 64'(req_cnt), 4);
        chk("basic_outstanding", 64'(outstanding), 4);
        chk("basic_vld_off", 64'(msgld_req.vld), 0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 8'(i), pat(64'h1000 + 64'(i) * 64));
        chk("basic_drained", 64'(outstanding), 0);
        chk("basic_done_lat1", 64'(done), 0);
        cycle(1'b1, 1'b0, 8'd0, '0);
        chk("basic_done_lat2", 64'(done), 1);
        cycle(1'b1, 1'b0, 8'd0, '0);
        chk("basic_idle", 64'(busy), 0);
        chk("basic_err", 64'(err_cnt), 0);
        chk("basic_req_hold", 64'(req_cnt), 4);
        chk("basic_sb_empty", 64'(sb_q.size()), 0);

        // pool exhaustion with responses withheld
        start_run(40, 64'h2000, 12'd128);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 8'd0, '0);
        chk("full_req_cnt", 64'(req_cnt), 16);
        chk("full_outstanding", 64'(outstanding), 16);
        chk("full_vld", 64'(msgld_req.vld), 0);
        cycle(1'b1, 1'b1, 8'd5, pat(m_addr[5]));
        chk("full_refill_vld", 64'(msgld_req.vld), 1);
        chk("full_refill_tag", 64'(msgld_req.intf.tag), 5);
        run_to_done(1'b0, 300);
        chk("full_req_total", 64'(req_cnt), 40);
        chk("full_err", 64'(err_cnt), 0);

        // random request back-pressure
        start_run(12, 64'h3000, 12'd100);
        run_to_done(1'b1, 400);
        chk("stall_req_cnt", 64'(req_cnt), 12);
        chk("stall_err", 64'(err_cnt), 0);

        // response on a never-allocated tag
        start_run(2, 64'h4000, 12'd16);
        cycle(1'b1, 1'b0, 8'd0, '0);
        cycle(1'b1, 1'b0, 8'd0, '0);
        cycle(1'b1, 1'b1, 8'd9, '0);
        chk("badtag_err", 64'(err_cnt), 1);
        chk("badtag_outstanding", 64'(outstanding), 2);
        run_to_done(1'b0, 50);
        chk("badtag_err_hold", 64'(err_cnt), 1);

        // one corrupted lane on a single beat
`ifdef CDM_MSGLD_DATA_CHECK_EN
        exp_data_err = 1;
`else
        exp_data_err = 0;
`endif
        start_run(1, 64'h5000, 12'd32);
        cycle(1'b1, 1'b0, 8'd0, '0);
        bad = pat(64'h5000);
        bad[3*32] = ~bad[3*32];
        cycle(1'b1, 1'b1, 8'd0, bad);
        run_to_done(1'b0, 20);
        chk("data_err", 64'(err_cnt), 64'(exp_data_err));

        // asynchronous reset with 3 outstanding
        start_run(8, 64'h6000, 12'd8);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'd0, '0);
        msgld_req.rdy = 1'b0;
        chk("pre_rst_outstanding", 64'(outstanding), 3);
        #2 user_reset = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 0);
        chk("midrst_outstanding", 64'(outstanding), 0);
        chk("midrst_vld", 64'(msgld_req.vld), 0);
        chk("midrst_rsp_rdy", 64'(msgld_rsp.rdy), 0);
        m_alloc = '0;
        sb_q.delete();
        stalled = 1'b0;
        @(posedge user_clk);
        #1;
        user_reset = 1'b0;
        start_run(2, 64'h7000, 12'd4);
        cycle(1'b1, 1'b0, 8'd0, '0);
        cycle(1'b1, 1'b0, 8'd0, '0);
        chk("postrst_outstanding", 64'(outstanding), 2);
        run_to_done(1'b0, 50);
        chk("postrst_req_cnt", 64'(req_cnt), 2);
        chk("postrst_err", 64'(err_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
